ssd_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the Pmod seven-segment display driven by the encoder count. Holds a double-buffered display value and cycles one-hot digit enables over a shared segment bus. Inserts a blanking gap between digits to suppress ghosting. Applies new values only at frame boundaries and acknowledges them, so the encoder logic never produces a torn display.

---
 rtl/ssd_scan_ctrl_pkg.sv | 11 +
 rtl/ssd_scan_ctrl_hex_to_seg.sv | 10 +
 rtl/ssd_scan_ctrl.sv | 114 +++++++++++
 tb/tb_ssd_scan_ctrl.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/ssd_scan_ctrl_pkg.sv
// ssd_pkg: shared segment table, scan state type and output polarity helper
package ssd_pkg;
  typedef enum logic {BLANK, DRIVE} state_e;
  localparam logic [6:0] SEG_LUT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  function automatic logic [7:0] apply_pol(input logic [7:0] v, input logic inv);
    return inv ? ~v : v;
  endfunction
endpackage

// File: rtl/ssd_scan_ctrl_hex_to_seg.sv
// hex_to_seg: nibble to active-high a..g segment pattern
module hex_to_seg
  import ssd_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);
  // pure table lookup, shared by every digit through the nibble mux
  always_comb seg_o = SEG_LUT[nib_i];
endmodule

// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl: double-buffered multiplexed seven-segment scan with blanking gaps
module ssd_scan_ctrl
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS     = 2,
  parameter int REFRESH_DIV    = 100000,
  parameter int BLANK_CYC      = 1000,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic                    lz_blank_i,
  input  logic                    load_i,
  output logic                    load_ack_o,
  output logic                    frame_o,
  output logic [6:0]              seg_o,
  output logic                    dp_o,
  output logic [NUM_DIGITS-1:0]   dig_o
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int VW = 4 * NUM_DIGITS;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYC);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic SEG_INV = SEG_ACTIVE_LOW != 0;
  localparam logic DIG_INV = DIG_ACTIVE_LOW != 0;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [VW-1:0]          disp_val_q, disp_val_d, stg_val_q, stg_val_d;
  logic [NUM_DIGITS-1:0]  disp_dp_q, disp_dp_d, stg_dp_q, stg_dp_d;
  logic                   pend_q, pend_d, ack_q, ack_d, frame_q, frame_d;
  logic [7:0]             segdp_q, segdp_d;
  logic [NUM_DIGITS-1:0]  dig_q, dig_d;
  logic                   wrap, boundary, commit, lit, lz_run;
  logic [NUM_DIGITS-1:0]  lz_mask;
  logic [3:0]             nib;
  logic [6:0]             seg_raw;

  hex_to_seg u_dec (.nib_i(nib), .seg_o(seg_raw));

  // slot timing, digit rotation and frame-boundary commit of the staged value
  always_comb begin
    wrap       = cnt_q == CNT_LAST;
    boundary   = wrap && idx_q == IDX_LAST;
    commit     = boundary && (pend_q || load_i);
    cnt_d      = wrap ? '0 : cnt_q + CW'(1);
    idx_d      = wrap ? (idx_q == IDX_LAST ? '0 : idx_q + IW'(1)) : idx_q;
    state_d    = cnt_d >= BLANK_END ? DRIVE : BLANK;
    disp_val_d = commit ? (load_i ? value_i : stg_val_q) : disp_val_q;
    disp_dp_d  = commit ? (load_i ? dp_i : stg_dp_q) : disp_dp_q;
    stg_val_d  = load_i && !boundary ? value_i : stg_val_q;
    stg_dp_d   = load_i && !boundary ? dp_i : stg_dp_q;
    pend_d     = boundary ? 1'b0 : pend_q | load_i;
    frame_d    = boundary;
    ack_d      = commit;
  end

  // next-cycle pin values, computed from next state so the pins come straight off flops
  always_comb begin
    lz_mask = '0;
    lz_run  = lz_blank_i;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      lz_run     = lz_run && disp_val_d[4*k +: 4] == 4'h0;
      lz_mask[k] = lz_run;
    end
    nib     = disp_val_d[{idx_d, 2'b00} +: 4];
    lit     = state_d == DRIVE && !lz_mask[idx_d];
    segdp_d = apply_pol({lit && disp_dp_d[idx_d], lit ? seg_raw : 7'h00}, SEG_INV);
    dig_d   = (state_d == DRIVE ? NUM_DIGITS'(1) << idx_d : '0) ^ {NUM_DIGITS{DIG_INV}};
  end

  // state register; reset returns to blanking on digit 0 and drops any staged load
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BLANK;
      cnt_q      <= '0;
      idx_q      <= '0;
      disp_val_q <= '0;
      disp_dp_q  <= '0;
      stg_val_q  <= '0;
      stg_dp_q   <= '0;
      pend_q     <= 1'b0;
      ack_q      <= 1'b0;
      frame_q    <= 1'b0;
      segdp_q    <= apply_pol(8'h00, SEG_INV);
      dig_q      <= {NUM_DIGITS{DIG_INV}};
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      disp_val_q <= disp_val_d;
      disp_dp_q  <= disp_dp_d;
      stg_val_q  <= stg_val_d;
      stg_dp_q   <= stg_dp_d;
      pend_q     <= pend_d;
      ack_q      <= ack_d;
      frame_q    <= frame_d;
      segdp_q    <= segdp_d;
      dig_q      <= dig_d;
    end
  end

  assign load_ack_o = ack_q;
  assign frame_o    = frame_q;
  assign seg_o      = segdp_q[6:0];
  assign dp_o       = segdp_q[7];
  assign dig_o      = dig_q;
endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// tb_ssd_scan_ctrl: scoreboard bench for the scan controller with 2 digits, 8-cycle slots
module tb_ssd_scan_ctrl;
  logic       clk = 1'b0, rst = 1'b1, load_i = 1'b0, lz_blank_i = 1'b0;
  logic [7:0] value_i = '0;
  logic [1:0] dp_i = '0;
  logic       load_ack_o, frame_o, dp_o;
  logic [6:0] seg_o;
  logic [1:0] dig_o;

  always #5 clk = ~clk;

  ssd_scan_ctrl #(
    .NUM_DIGITS(2), .REFRESH_DIV(8), .BLANK_CYC(2), .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(0)
  ) dut (
    .clk(clk), .rst(rst), .value_i(value_i), .dp_i(dp_i), .lz_blank_i(lz_blank_i),
    .load_i(load_i), .load_ack_o(load_ack_o), .frame_o(frame_o),
    .seg_o(seg_o), .dp_o(dp_o), .dig_o(dig_o)
  );

  typedef struct {
    int         cyc;
    logic [1:0] dig;
    logic [6:0] seg;
    logic       dp;
    logic       frame;
    logic       ack;
  } exp_t;

  exp_t sb[$];
  logic [6:0] lut [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };
  int total = 0, bad = 0;

  int         c;
  logic [7:0] m_val, s_val;
  logic [1:0] m_dp, s_dp;
  logic       pend, ack_nx, lz_prev;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_exp();
    exp_t e;
    int   slot = c % 8;
    int   idx = (c / 8) % 2;
    logic blank = idx == 1 && lz_prev && m_val[7:4] == 4'h0;
    logic [3:0] nib = idx == 1 ? m_val[7:4] : m_val[3:0];
    e.cyc   = c;
    e.frame = c > 0 && c % 16 == 0;
    e.ack   = ack_nx;
    e.dig   = slot >= 2 ? (idx == 1 ? 2'b10 : 2'b01) : 2'b00;
    e.seg   = slot >= 2 && !blank ? lut[nib] : 7'h00;
    e.dp    = slot >= 2 && !blank ? m_dp[idx] : 1'b0;
    sb.push_back(e);
  endtask

  task automatic step(logic ld, logic [7:0] v, logic [1:0] d);
    logic bnd;
    push_exp();
    load_i  = ld;
    value_i = v;
    dp_i    = d;
    bnd     = c % 16 == 15;
    ack_nx  = bnd && (pend || ld);
    if (bnd) begin
      if (pend || ld) begin
        m_val = ld ? v : s_val;
        m_dp  = ld ? d : s_dp;
      end
      pend = 1'b0;
    end else if (ld) begin
      s_val = v;
      s_dp  = d;
      pend  = 1'b1;
    end
    lz_prev = lz_blank_i;
    c++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    exp_t e;
    rst     = 1'b1;
    load_i  = 1'b1;
    value_i = 8'hFF;
    dp_i    = 2'b11;
    @(posedge clk);
    #1;
    e.cyc = -1; e.dig = '0; e.seg = '0; e.dp = 1'b0; e.frame = 1'b0; e.ack = 1'b0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    rst = 1'b0; load_i = 1'b0; value_i = '0; dp_i = '0;
    c = 0; m_val = '0; s_val = '0; m_dp = '0; s_dp = '0;
    pend = 1'b0; ack_nx = 1'b0; lz_prev = lz_blank_i;
  endtask

  task automatic run(int n, int c1, logic [7:0] v1, logic [1:0] p1,
                     int c2, logic [7:0] v2, logic [1:0] p2);
    for (int i = 0; i < n; i++) begin
      if (c == c1) step(1'b1, v1, p1);
      else if (c == c2) step(1'b1, v2, p2);
      else step(1'b0, 8'h00, 2'b00);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t  e;
      string t;
      e = sb.pop_front();
      t = $sformatf("c%0d", e.cyc);
      check({t, ".dig"}, 32'(dig_o), 32'(e.dig));
      check({t, ".seg"}, 32'(seg_o), 32'(e.seg));
      check({t, ".dp"}, 32'(dp_o), 32'(e.dp));
      check({t, ".frame"}, 32'(frame_o), 32'(e.frame));
      check({t, ".ack"}, 32'(load_ack_o), 32'(e.ack));
    end
  end

  initial begin
    do_reset();
    run(32, -1, 8'h00, 2'b00, -1, 8'h00, 2'b00);
    do_reset();
    run(40, 3, 8'h3A, 2'b00, -1, 8'h00, 2'b00);
    do_reset();
    run(40, 4, 8'h12, 2'b01, 9, 8'h34, 2'b10);
    do_reset();
    run(40, 15, 8'h56, 2'b11, -1, 8'h00, 2'b00);
    lz_blank_i = 1'b1;
    do_reset();
    run(40, 3, 8'h07, 2'b10, -1, 8'h00, 2'b00);
    run(24, 40, 8'h00, 2'b01, -1, 8'h00, 2'b00);
    lz_blank_i = 1'b0;
    do_reset();
    run(10, 3, 8'h99, 2'b11, -1, 8'h00, 2'b00);
    do_reset();
    run(40, -1, 8'h00, 2'b00, -1, 8'h00, 2'b00);
    @(negedge clk);
    #1;
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
